lgn_infer_ctrl: RTL and testbench

- Sequences one inference of the combinational/pipelined logic-gate network.
- Frames UART input with a sync byte and loads the network input register.
- Waits out the network latency, then captures class scores and computes their argmax serially.
- Streams the scores plus the argmax byte to the UART transmitter.
- Sits between uart_rx/uart_tx and logic_network at top level, replacing the ad-hoc top-level FSM.

---
 rtl/lgn_pkg.sv | 22 ++
 rtl/lgn_tx_seq.sv | 61 ++++++
 rtl/lgn_infer_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_lgn_infer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lgn_pkg.sv
// Shared types and helpers for the logic-gate-network inference controller.
package lgn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CAPTURE,
    ST_ARGMAX,
    ST_SEND,
    ST_TX_HI,
    ST_TX_LO
  } state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lgn_tx_seq.sv
// One-byte handshake with the UART transmitter: waits for idle, pulses tx_send,
// then follows tx_active high and low before reporting done.
module lgn_tx_seq
  import lgn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  input  logic       tx_active_i,
  output logic [7:0] tx_data_o,
  output logic       tx_send_o,
  output logic       done_o
);

  state_t     state_q, state_d;
  logic       fire;
  logic [7:0] tx_data_q;
  logic       tx_send_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i)      state_d = ST_SEND;
      ST_SEND:  if (!tx_active_i) state_d = ST_TX_HI;
      ST_TX_HI: if (tx_active_i)  state_d = ST_TX_LO;
      ST_TX_LO: if (!tx_active_i) state_d = ST_IDLE;
      default:                    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    fire   = (state_q == ST_SEND) && !tx_active_i;
    done_o = (state_q == ST_TX_LO) && !tx_active_i;
  end

  // tx_data only moves together with a request, so it stays put for the whole byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
    end else begin
      tx_send_q <= fire;
      if (fire) begin
        tx_data_q <= byte_i;
      end
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_send_o = tx_send_q;

endmodule

// File: rtl/lgn_infer_ctrl.sv
// Frames UART bytes into the network input, waits out network latency, scans the
// class scores for the argmax and streams scores plus argmax out through lgn_tx_seq.
module lgn_infer_ctrl #(
  parameter int         INPUT_BITS     = 400,
  parameter int         CLASSES        = 10,
  parameter int         BITS_PER_VALUE = 7,
  parameter int         NET_LATENCY    = 1,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0] SYNC_BYTE      = lgn_pkg::SYNC_BYTE
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic [7:0]                        tx_data,
  output logic                              tx_send,
  input  logic                              tx_active,
  output logic [INPUT_BITS-1:0]             net_x,
  input  logic [CLASSES*BITS_PER_VALUE-1:0] net_y,
  output logic                              busy,
  output logic [7:0]                        infer_count,
  output logic                              err_timeout
);

  import lgn_pkg::*;

  localparam int INPUT_BYTES = INPUT_BITS / 8;
  localparam int BW = cnt_w(INPUT_BYTES + 1);
  localparam int GW = cnt_w(TIMEOUT_CYCLES);
  localparam int LW = cnt_w(NET_LATENCY);
  localparam int IW = cnt_w(CLASSES + 1);

  localparam logic [BW-1:0] LAST_BYTE = BW'(INPUT_BYTES - 1);
  localparam logic [GW-1:0] GAP_MAX   = GW'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LAT_MAX   = LW'(NET_LATENCY - 1);
  localparam logic [IW-1:0] LAST_CLS  = IW'(CLASSES - 1);
  localparam logic [IW-1:0] N_CLS     = IW'(CLASSES);

  state_t                    state_q, state_d;
  logic [INPUT_BITS-1:0]     net_x_q;
  logic [BW-1:0]             byte_cnt_q;
  logic [GW-1:0]             gap_cnt_q;
  logic [LW-1:0]             lat_cnt_q;
  logic [BITS_PER_VALUE-1:0] score_q [CLASSES];
  logic [BITS_PER_VALUE-1:0] best_val_q;
  logic [BITS_PER_VALUE-1:0] scan_val;
  logic [IW-1:0]             best_idx_q, scan_idx_q, tx_idx_q;
  logic                      tx_start_q, tx_done;
  logic [7:0]                infer_cnt_q, tx_byte;
  logic                      err_q;
  logic                      sync_hit, last_byte, gap_expired, lat_done, scan_last, frame_sent;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ST_SEND covers the whole per-byte handshake; its sub-phases live in lgn_tx_seq.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (sync_hit) state_d = ST_LOAD;
      ST_LOAD: begin
        if (rx_valid) begin
          if (last_byte) state_d = ST_WAIT;
        end else if (gap_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT:    if (lat_done) state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = (CLASSES == 1) ? ST_SEND : ST_ARGMAX;
      ST_ARGMAX:  if (scan_last) state_d = ST_SEND;
      ST_SEND:    if (frame_sent) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != ST_IDLE);
    sync_hit    = rx_valid && (rx_data == SYNC_BYTE);
    last_byte   = (byte_cnt_q == LAST_BYTE);
    gap_expired = (gap_cnt_q == GAP_MAX);
    lat_done    = (lat_cnt_q == LAT_MAX);
    scan_last   = (scan_idx_q == LAST_CLS);
    frame_sent  = tx_done && (tx_idx_q == N_CLS);
    scan_val    = score_q[0];
    tx_byte     = 8'(best_idx_q);
    for (int c = 0; c < CLASSES; c++) begin
      if (scan_idx_q == IW'(c)) scan_val = score_q[c];
      if (tx_idx_q == IW'(c))   tx_byte  = 8'(score_q[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      net_x_q     <= '0;
      byte_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      for (int c = 0; c < CLASSES; c++) score_q[c] <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      scan_idx_q  <= '0;
      tx_idx_q    <= '0;
      tx_start_q  <= 1'b0;
      infer_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sync_hit) begin
            byte_cnt_q <= '0;
            gap_cnt_q  <= '0;
          end
        end
        ST_LOAD: begin
          if (rx_valid) begin
            for (int b = 0; b < INPUT_BYTES; b++) begin
              if (byte_cnt_q == BW'(b)) net_x_q[b*8 +: 8] <= rx_data;
            end
            byte_cnt_q <= byte_cnt_q + 1'b1;
            gap_cnt_q  <= '0;
            lat_cnt_q  <= '0;
          end else if (gap_expired) begin
            err_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (!lat_done) lat_cnt_q <= lat_cnt_q + 1'b1;
        end
        ST_CAPTURE: begin
          for (int c = 0; c < CLASSES; c++) begin
            score_q[c] <= net_y[c*BITS_PER_VALUE +: BITS_PER_VALUE];
          end
          best_idx_q <= '0;
          best_val_q <= net_y[BITS_PER_VALUE-1:0];
          scan_idx_q <= IW'(1);
          if (CLASSES == 1) begin
            tx_idx_q   <= '0;
            tx_start_q <= 1'b1;
          end
        end
        ST_ARGMAX: begin
          // Strict compare keeps the lowest index on ties.
          if (scan_val > best_val_q) begin
            best_val_q <= scan_val;
            best_idx_q <= scan_idx_q;
          end
          scan_idx_q <= scan_idx_q + 1'b1;
          if (scan_last) begin
            tx_idx_q   <= '0;
            tx_start_q <= 1'b1;
          end
        end
        ST_SEND: begin
          if (tx_done) begin
            if (tx_idx_q == N_CLS) begin
              infer_cnt_q <= infer_cnt_q + 1'b1;
            end else begin
              tx_idx_q   <= tx_idx_q + 1'b1;
              tx_start_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  lgn_tx_seq u_tx_seq (
    .clk         (clk),
    .rst         (rst),
    .start_i     (tx_start_q),
    .byte_i      (tx_byte),
    .tx_active_i (tx_active),
    .tx_data_o   (tx_data),
    .tx_send_o   (tx_send),
    .done_o      (tx_done)
  );

  assign net_x       = net_x_q;
  assign infer_count = infer_cnt_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_lgn_infer_ctrl.sv
// Directed bench for lgn_infer_ctrl with a delayed XOR-fold network and a UART transmitter model.
module tb_lgn_infer_ctrl;

  localparam int IB  = 400;
  localparam int NB  = IB / 8;
  localparam int NC  = 10;
  localparam int BPV = 7;
  localparam int NL  = 4;
  localparam int TO  = 100;
  localparam logic [7:0] SYNC = 8'hA5;

  logic              clk = 1'b0;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [7:0]        tx_data;
  logic              tx_send;
  logic              tx_active;
  logic [IB-1:0]     net_x;
  logic [NC*BPV-1:0] net_y;
  logic              busy;
  logic [7:0]        infer_count;
  logic              err_timeout;

  int         total = 0;
  int         bad = 0;
  int         n_send = 0;
  int         n_err = 0;
  int         tx_hold = 3;
  logic [7:0] exp_cnt = 8'd0;
  logic [7:0] pl [NB];
  logic [6:0] key [NC];
  logic [7:0] exp_q [$];
  logic [7:0] sent_log [$];
  logic [NC*BPV-1:0] pipe [NL];

  lgn_infer_ctrl #(
    .INPUT_BITS(IB), .CLASSES(NC), .BITS_PER_VALUE(BPV),
    .NET_LATENCY(NL), .TIMEOUT_CYCLES(TO), .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_send(tx_send), .tx_active(tx_active),
    .net_x(net_x), .net_y(net_y), .busy(busy),
    .infer_count(infer_count), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Network: score c is the XOR of bytes c, c+10, .., c+40 (low 7 bits) ^ key[c], NL cycles late.
  function automatic logic [NC*BPV-1:0] net_fn(input logic [IB-1:0] x);
    logic [NC*BPV-1:0] y;
    y = '0;
    for (int c = 0; c < NC; c++) begin
      logic [7:0] f;
      f = 8'h00;
      for (int k = 0; k < NB / NC; k++) f = f ^ x[(c + NC*k)*8 +: 8];
      y[c*BPV +: BPV] = f[6:0] ^ key[c];
    end
    return y;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= net_fn(net_x);
    for (int i = 1; i < NL; i++) pipe[i] <= pipe[i-1];
  end
  assign net_y = pipe[NL-1];

  function automatic logic [6:0] fold7(input int c);
    logic [7:0] f;
    f = 8'h00;
    for (int k = 0; k < NB / NC; k++) f = f ^ pl[c + NC*k];
    return f[6:0];
  endfunction

  function automatic logic [IB-1:0] pl_vec();
    logic [IB-1:0] v;
    for (int i = 0; i < NB; i++) v[i*8 +: 8] = pl[i];
    return v;
  endfunction

  task automatic push_expected();
    logic [6:0] sc [NC];
    int best;
    best = 0;
    for (int c = 0; c < NC; c++) sc[c] = fold7(c) ^ key[c];
    for (int c = 1; c < NC; c++) if (sc[c] > sc[best]) best = c;
    for (int c = 0; c < NC; c++) exp_q.push_back({1'b0, sc[c]});
    exp_q.push_back(8'(best));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_x(input string name, input logic [IB-1:0] exp);
    total++;
    if (net_x !== exp) begin
      bad++;
      $display("FAIL %s: net_x got 0x%0h, expected 0x%0h", name, net_x, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check("wait_idle_busy", busy, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_tx_data"}, tx_data, 0);
    check({name, "_tx_send"}, tx_send, 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_infer_count"}, infer_count, 0);
    check({name, "_err_timeout"}, err_timeout, 0);
    check_x({name, "_net_x"}, '0);
  endtask

  task automatic run_frame(input int gap, input bit inject);
    int s0;
    s0 = n_send;
    push_expected();
    send_byte(SYNC, gap);
    for (int i = 0; i < NB; i++) send_byte(pl[i], gap);
    if (inject) begin
      int w;
      w = 0;
      while (n_send == s0 && w < 2000) begin
        tick();
        w++;
      end
      check("first_send_seen", 64'(n_send != s0), 1);
      send_byte(SYNC, 0);
      send_byte(8'h3C, 0);
      send_byte(SYNC, 2);
    end
    wait_idle(20000);
    exp_cnt = exp_cnt + 8'd1;
    check("infer_count", infer_count, exp_cnt);
    check("send_count", 64'(n_send - s0), NC + 1);
    check("exp_q_drained", 64'(exp_q.size()), 0);
    check_x("net_x_frame", pl_vec());
  endtask

  // Per-cycle compare of the transmit side, plus the transmitter model.
  initial begin
    logic [7:0] prev_dat;
    logic [7:0] e;
    bit         pend;
    int         hold;
    tx_active = 1'b0;
    prev_dat  = 8'h00;
    pend      = 1'b0;
    hold      = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tx_active = 1'b0;
        pend      = 1'b0;
      end else begin
        if (tx_send) begin
          n_send++;
          sent_log.push_back(tx_data);
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL tx_byte: unexpected byte 0x%0h, none expected", tx_data);
          end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
              bad++;
              $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", tx_data, e);
            end
          end
          total++;
          if (tx_active !== 1'b0) begin
            bad++;
            $display("FAIL tx_send_while_active: tx_active=%b, required 0", tx_active);
          end
        end else begin
          total++;
          if (tx_data !== prev_dat) begin
            bad++;
            $display("FAIL tx_data_stable: got 0x%0h, held 0x%0h", tx_data, prev_dat);
          end
        end
        if (err_timeout) n_err++;
        if (pend) begin
          tx_active = 1'b1;
          hold      = tx_hold;
          pend      = 1'b0;
        end else if (tx_active) begin
          if (hold <= 1) tx_active = 1'b0;
          else hold--;
        end
        if (tx_send) pend = 1'b1;
      end
      prev_dat = tx_data;
    end
  end

  initial begin
    logic [6:0] want [NC];
    logic [7:0] lit_tx [NC+1];
    int s0;
    int at;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    for (int c = 0; c < NC; c++) key[c] = 7'h00;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // Reset in the middle of LOAD.
    for (int i = 0; i < NB; i++) pl[i] = 8'(i * 3 + 1);
    send_byte(SYNC, 1);
    for (int i = 0; i < 20; i++) send_byte(pl[i], 1);
    check("mid_load_busy", busy, 1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("mid_reset");

    // Nominal frame with scores pinned to 3,9,1,9,0,0,0,0,0,2.
    for (int i = 0; i < NB; i++) pl[i] = 8'(i);
    want = '{7'd3, 7'd9, 7'd1, 7'd9, 7'd0, 7'd0, 7'd0, 7'd0, 7'd0, 7'd2};
    for (int c = 0; c < NC; c++) key[c] = fold7(c) ^ want[c];
    sent_log.delete();
    run_frame(1, 1'b0);
    check("nom_infer_count", infer_count, 8'd1);
    check("nom_x_lo", net_x[7:0], 8'h00);
    check("nom_x_hi", net_x[399:392], 8'h31);
    lit_tx = '{8'h03, 8'h09, 8'h01, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h02, 8'h01};
    check("nom_tx_len", 64'(sent_log.size()), NC + 1);
    for (int i = 0; i < NC + 1 && i < sent_log.size(); i++) check("nom_tx_lit", sent_log[i], lit_tx[i]);

    // Sync hunting with SYNC values inside the payload.
    for (int i = 0; i < NB; i++) pl[i] = 8'(i * 7 + 3);
    pl[5] = SYNC;
    pl[6] = SYNC;
    send_byte(8'h11, 1);
    send_byte(8'h22, 1);
    run_frame(2, 1'b0);
    check("hunt_byte5", net_x[47:40], 8'hA5);
    check("hunt_byte6", net_x[55:48], 8'hA5);

    // Timeout: sync plus 10 bytes then silence.
    s0 = n_send;
    for (int i = 0; i < 10; i++) pl[i] = 8'($urandom_range(0, 255));
    send_byte(SYNC, 1);
    for (int i = 0; i < 9; i++) send_byte(pl[i], 1);
    send_byte(pl[9], 0);
    at = -1;
    for (int i = 1; i <= TO + 50; i++) begin
      tick();
      if (err_timeout) begin
        at = i;
        break;
      end
    end
    check("timeout_delay", 64'(at), TO);
    check("timeout_busy", busy, 0);
    tick();
    check("timeout_pulse_width", err_timeout, 0);
    check("timeout_no_send", 64'(n_send - s0), 0);
    check_x("timeout_partial_x", pl_vec());

    // Recovery and latency: consecutive frames with different scores.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < NB; i++) pl[i] = 8'($urandom_range(0, 255));
      run_frame(f, 1'b0);
    end

    // Transmitter backpressure with rx bytes arriving while sending.
    tx_hold = 500;
    for (int i = 0; i < NB; i++) pl[i] = 8'($urandom_range(0, 255));
    run_frame(1, 1'b1);
    tx_hold = 3;
    repeat (5) tick();
    check("idle_after_inject", busy, 0);
    check("err_pulse_total", 64'(n_err), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
